// File: rtl/fecg_acq_pkg.sv
// Shared types and default dimensions for the fetal-ECG acquisition bank scheduler.
package fecg_acq_pkg;

   localparam int unsigned N_SAMPLES_DEF  = 512;
   localparam int unsigned N_CHANNELS_DEF = 8;
   localparam int unsigned DATA_W_DEF     = 32;

   localparam int unsigned SAMPLE_IDX_W = $clog2(N_SAMPLES_DEF);
   localparam int unsigned CH_IDX_W     = $clog2(N_CHANNELS_DEF);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SYNC,
      FILL,
      STALL
   } acq_state_t;

endpackage

// File: rtl/up_counter.sv
// Wrapping up-counter: counts 0..MAX_VALUE-1 on enable, flags the last value on max.
module up_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_VALUE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             max
);

   assign max = (count == WIDTH'(MAX_VALUE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= max ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/acq_bank_scheduler.sv
// Ping-pong accumulator bank scheduler: write sequencing, full-bank tracking, consumer handshake.
// Optional ACQ_DROP_COUNT_EN adds a saturating drop_count output.
module acq_bank_scheduler
   import fecg_acq_pkg::*;
#(
   parameter int unsigned N_SAMPLES  = N_SAMPLES_DEF,
   parameter int unsigned N_CHANNELS = N_CHANNELS_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          word_valid,
   input  logic                          word_first,
   input  logic [DATA_W-1:0]             word_data,
   output logic                          wr_en,
   output logic                          wr_bank,
   output logic [$clog2(N_SAMPLES)-1:0]  wr_sample,
   output logic [$clog2(N_CHANNELS)-1:0] wr_channel,
   output logic [DATA_W-1:0]             wr_data,
   output logic                          blk_valid,
   output logic                          blk_bank,
   input  logic                          blk_ack,
   output logic                          overflow,
`ifdef ACQ_DROP_COUNT_EN
   output logic [15:0]                   drop_count,
`endif
   output logic                          sync_err
);

   localparam int unsigned S_W = $clog2(N_SAMPLES);
   localparam int unsigned C_W = $clog2(N_CHANNELS);

   acq_state_t     state;
   logic           fill_bank;
   logic [1:0]     full;
   logic [C_W-1:0] ch_idx;
   logic [S_W-1:0] sample_cnt;
   logic           sample_max;

   logic           ack_fire, other_free, last_ch, take, realign, adv, done, stall_go;
   logic           wr_go, tgt_bank, drop, cnt_clr, bank_next;
   logic [S_W-1:0] tgt_sample;
   logic [C_W-1:0] tgt_ch, ch_next;
   logic [1:0]     full_next;

   up_counter #(
      .WIDTH     (S_W),
      .MAX_VALUE (N_SAMPLES)
   ) u_sample_cnt (
      .clk    (clk),
      .rst_n  (rst),
      .clear  (cnt_clr),
      .enable (adv),
      .count  (sample_cnt),
      .max    (sample_max)
   );

   always_comb begin
      ack_fire   = blk_ack && blk_valid;
      // An ack landing on the other bank this edge counts as freeing it.
      other_free = !full[~fill_bank] || (ack_fire && (blk_bank == ~fill_bank));
      last_ch    = (ch_idx == C_W'(N_CHANNELS - 1));
      take       = enable && word_valid &&
                   ((state == FILL) || ((state == WAIT_SYNC) && word_first));
      realign    = (state == FILL) && word_first && (ch_idx != '0);
      adv        = take && (last_ch || realign);
      done       = adv && sample_max;
      stall_go   = done && !other_free;
      cnt_clr    = (state == FILL) && !enable;

      wr_go      = take;
      tgt_bank   = fill_bank;
      tgt_sample = sample_cnt;
      tgt_ch     = ch_idx;
      ch_next    = last_ch ? '0 : ch_idx + 1'b1;
      // A misaligned first word closes the current sample; at the last sample
      // that closes the block and the word opens the next bank, if it is free.
      if (realign) begin
         tgt_ch  = '0;
         ch_next = C_W'(1);
         if (sample_max) begin
            tgt_bank   = ~fill_bank;
            tgt_sample = '0;
            wr_go      = other_free;
            if (!other_free) ch_next = '0;
         end else begin
            tgt_sample = sample_cnt + 1'b1;
         end
      end

      drop = ((state == STALL) && word_valid) || (take && !wr_go);

      full_next = full;
      if (ack_fire) full_next[blk_bank] = 1'b0;
      if (done)     full_next[fill_bank] = 1'b1;
      bank_next = full_next[blk_bank]  ? blk_bank :
                  full_next[~blk_bank] ? ~blk_bank : blk_bank;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fill_bank  <= 1'b0;
         full       <= '0;
         ch_idx     <= '0;
         wr_en      <= 1'b0;
         wr_bank    <= 1'b0;
         wr_sample  <= '0;
         wr_channel <= '0;
         wr_data    <= '0;
         blk_valid  <= 1'b0;
         blk_bank   <= 1'b0;
         overflow   <= 1'b0;
         sync_err   <= 1'b0;
`ifdef ACQ_DROP_COUNT_EN
         drop_count <= '0;
`endif
      end else begin
         wr_en <= wr_go;
         if (wr_go) begin
            wr_bank    <= tgt_bank;
            wr_sample  <= tgt_sample;
            wr_channel <= tgt_ch;
            wr_data    <= word_data;
         end

         full      <= full_next;
         blk_valid <= |full_next;
         blk_bank  <= bank_next;

         if (drop) overflow <= 1'b1;
         if (take && realign) sync_err <= 1'b1;
`ifdef ACQ_DROP_COUNT_EN
         if (drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
`endif

         if (done) fill_bank <= ~fill_bank;

         if (cnt_clr)   ch_idx <= '0;
         else if (take) ch_idx <= ch_next;

         case (state)
            IDLE:      if (enable) state <= WAIT_SYNC;
            WAIT_SYNC: begin
               if (!enable)   state <= IDLE;
               else if (take) state <= stall_go ? STALL : FILL;
            end
            FILL: begin
               if (!enable)       state <= IDLE;
               else if (stall_go) state <= STALL;
            end
            STALL:     if (ack_fire && (blk_bank == fill_bank)) state <= WAIT_SYNC;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acq_bank_scheduler.sv
// Scoreboard bench for acq_bank_scheduler with 4 samples x 2 channels per block.
module tb_acq_bank_scheduler;

   localparam int unsigned NS = 4;
   localparam int unsigned NC = 2;

   typedef struct packed {
      logic        bank;
      logic [1:0]  s;
      logic        c;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        word_valid = 1'b0;
   logic        word_first = 1'b0;
   logic [31:0] word_data = '0;
   logic        blk_ack = 1'b0;
   logic        wr_en, wr_bank, blk_valid, blk_bank, overflow, sync_err;
   logic [1:0]  wr_sample;
   logic        wr_channel;
   logic [31:0] wr_data;
`ifdef ACQ_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   logic blk_q[$];

   acq_bank_scheduler #(
      .N_SAMPLES  (NS),
      .N_CHANNELS (NC),
      .DATA_W     (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .word_valid (word_valid),
      .word_first (word_first),
      .word_data  (word_data),
      .wr_en      (wr_en),
      .wr_bank    (wr_bank),
      .wr_sample  (wr_sample),
      .wr_channel (wr_channel),
      .wr_data    (wr_data),
      .blk_valid  (blk_valid),
      .blk_bank   (blk_bank),
      .blk_ack    (blk_ack),
      .overflow   (overflow),
`ifdef ACQ_DROP_COUNT_EN
      .drop_count (drop_count),
`endif
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Monitor: writes and block offers are popped from the scoreboard queues.
   initial begin
      wr_t  act, e;
      logic pv = 1'b0;
      logic pb = 1'b0;
      logic eb;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            checks++;
            act = '{bank: wr_bank, s: wr_sample, c: wr_channel, d: wr_data};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got bank=%0d s=%0d c=%0d d=%h, required no write",
                        act.bank, act.s, act.c, act.d);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL wr: got bank=%0d s=%0d c=%0d d=%h, required bank=%0d s=%0d c=%0d d=%h",
                           act.bank, act.s, act.c, act.d, e.bank, e.s, e.c, e.d);
               end
            end
         end
         if (blk_valid && (!pv || (blk_bank != pb))) begin
            checks++;
            if (blk_q.size() == 0) begin
               errors++;
               $display("FAIL blk_unexpected: got offer of bank %0d, required none", blk_bank);
            end else begin
               eb = blk_q.pop_front();
               if (blk_bank !== eb) begin
                  errors++;
                  $display("FAIL blk_bank: got %0d, required %0d", blk_bank, eb);
               end
            end
         end
         pv = blk_valid;
         pb = blk_bank;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic f);
      word_valid = 1'b1;
      word_first = f;
      word_data  = d;
      tick();
      word_valid = 1'b0;
      word_first = 1'b0;
   endtask

   task automatic w(input logic [31:0] d, input logic f, input logic b,
                    input logic [1:0] s, input logic c);
      exp_q.push_back('{bank: b, s: s, c: c, d: d});
      send(d, f);
   endtask

   // Eight aligned words into bank b; ack raised during word index ack_at.
   task automatic fill(input logic [31:0] base, input logic b, input int unsigned ack_at);
      for (int unsigned i = 0; i < 8; i++) begin
         blk_ack = (i == ack_at);
         w(base + i, (i % 2) == 0, b, 2'(i / 2), 1'(i % 2));
      end
      blk_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("reset_outputs", {wr_en, wr_bank, 2'b0, wr_sample, 3'b0, wr_channel, blk_valid,
                            blk_bank, overflow, sync_err}, '0);
      chk("reset_wr_data", wr_data, '0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic fill into bank0
      enable = 1'b1;
      tick();
      blk_q.push_back(1'b0);
      fill(32'h10, 1'b0, 99);
      chk("basic_blk_valid", {31'b0, blk_valid}, 1);
      chk("basic_blk_bank", {31'b0, blk_bank}, 0);

      // Ping-pong: bank1 fills without a gap, bank0 acked mid-way
      blk_q.push_back(1'b1);
      fill(32'h20, 1'b1, 4);
      chk("pp_blk_bank", {31'b0, blk_bank}, 1);
      chk("pp_overflow", {31'b0, overflow}, 0);
      blk_ack = 1'b1;
      tick();
      blk_ack = 1'b0;
      chk("pp_blk_released", {31'b0, blk_valid}, 0);

      // Overflow: both banks filled without ack, then drops in STALL
      blk_q.push_back(1'b0);
      fill(32'h30, 1'b0, 99);
      fill(32'h40, 1'b1, 99);
      chk("ov_before", {31'b0, overflow}, 0);
      send(32'h50, 1'b1);
      send(32'h51, 1'b0);
      send(32'h52, 1'b1);
      chk("ov_flag", {31'b0, overflow}, 1);
`ifdef ACQ_DROP_COUNT_EN
      chk("ov_drop_count3", {16'b0, drop_count}, 3);
`endif
      blk_q.push_back(1'b1);
      blk_ack = 1'b1;
      send(32'h53, 1'b0);
      blk_ack = 1'b0;
`ifdef ACQ_DROP_COUNT_EN
      chk("ov_drop_count4", {16'b0, drop_count}, 4);
`endif
      send(32'h54, 1'b0);
      w(32'h60, 1'b1, 1'b0, 2'd0, 1'b0);

      // Sync error: first flag on channel 1 realigns to the next sample
      chk("sync_before", {31'b0, sync_err}, 0);
      w(32'h61, 1'b1, 1'b0, 2'd1, 1'b0);
      chk("sync_err", {31'b0, sync_err}, 1);
      blk_ack = 1'b1;
      w(32'h62, 1'b0, 1'b0, 2'd1, 1'b1);
      blk_ack = 1'b0;
      blk_q.push_back(1'b0);
      w(32'h63, 1'b1, 1'b0, 2'd2, 1'b0);
      w(32'h64, 1'b0, 1'b0, 2'd2, 1'b1);
      w(32'h65, 1'b1, 1'b0, 2'd3, 1'b0);
      w(32'h66, 1'b0, 1'b0, 2'd3, 1'b1);
      chk("sync_blk_bank", {30'b0, blk_valid, blk_bank}, 32'h2);

      // Reset mid-block in bank1
      for (int unsigned i = 0; i < 5; i++)
         w(32'h70 + i, (i % 2) == 0, 1'b1, 2'(i / 2), 1'(i % 2));
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_outputs", {wr_en, wr_bank, blk_valid, blk_bank, overflow, sync_err}, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      w(32'h80, 1'b1, 1'b0, 2'd0, 1'b0);
      w(32'h81, 1'b0, 1'b0, 2'd0, 1'b1);
      w(32'h82, 1'b1, 1'b0, 2'd1, 1'b0);

      // Enable low mid-block abandons it; capture restarts at (0,0)
      enable = 1'b0;
      send(32'h83, 1'b0);
      chk("en_low_no_write", {31'b0, wr_en}, 0);
      enable = 1'b1;
      tick();
      send(32'h84, 1'b0);
      w(32'h85, 1'b1, 1'b0, 2'd0, 1'b0);

      // Simultaneous: bank1 completes in the same edge bank0 is acked
      blk_q.push_back(1'b0);
      w(32'h86, 1'b0, 1'b0, 2'd0, 1'b1);
      for (int unsigned i = 2; i < 8; i++)
         w(32'h85 + i, (i % 2) == 0, 1'b0, 2'(i / 2), 1'(i % 2));
      blk_q.push_back(1'b1);
      fill(32'h90, 1'b1, 7);
      w(32'h98, 1'b1, 1'b0, 2'd0, 1'b0);
      chk("sim_blk", {30'b0, blk_valid, blk_bank}, 32'h3);
      chk("sim_no_stall", {31'b0, overflow}, 0);

      tick();
      tick();
      chk("wr_queue_drained", exp_q.size(), 0);
      chk("blk_queue_drained", blk_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/acq_bank_scheduler.md
Name: acq_bank_scheduler

Overview:
- Sequences sample capture into a ping-pong pair of N_SAMPLES x N_CHANNELS x 32-bit accumulator banks, downstream of the serial deserializer.
- Generates write strobes and addresses for each bank and tracks which bank is full.
- Hands each completed block to the downstream consumer (whitening/ICA engine) with a valid/ack handshake.
- Drops incoming words and flags overflow when both banks are held.

Parameters:
- N_SAMPLES, 512, samples per block.
- N_CHANNELS, 8, electrode channels per sample.
- DATA_W, 32, sample word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; low = words ignored, state held.
- word_valid  in  1  one deserialized word present this cycle.
- word_first  in  1  qualifies word_valid; word is channel 0 of a sample.
- word_data  in  DATA_W  sample word.
- wr_en  out  1  bank write strobe.
- wr_bank  out  1  target bank.
- wr_sample  out  $clog2(N_SAMPLES)  sample index.
- wr_channel  out  $clog2(N_CHANNELS)  channel index.
- wr_data  out  DATA_W  registered word_data.
- blk_valid  out  1  a full bank is offered to the consumer.
- blk_bank  out  1  offered bank (oldest full).
- blk_ack  in  1  consumer finished with blk_bank; frees it.
- overflow  out  1  sticky: a word was dropped.
- sync_err  out  1  sticky: word_first arrived at channel index != 0.

Behaviour:
- Reset values: all outputs 0; fill_bank=0; sample/channel indices 0; both banks free; state IDLE.
- Write latency: 1 cycle. Accepted word at cycle t gives wr_en=1 at t+1 with its registered indices and data.
- Channel index increments per accepted word. It wraps at N_CHANNELS-1 and increments the sample index.
- Last word of a block (sample N_SAMPLES-1, channel N_CHANNELS-1):
  - marks fill_bank full;
  - toggles fill_bank;
  - resets both indices.
- A word arriving the very next cycle goes to the other bank with no gap, provided that bank is free.
- FSM states:
  - IDLE: enable=0. Words ignored. enable=1 -> WAIT_SYNC.
  - WAIT_SYNC: discard words until word_valid&word_first. That word is accepted as channel 0, sample 0 -> FILL.
  - FILL: accept words.
    - Block completes and the other bank is full -> STALL.
    - enable=0 -> IDLE; the partial block is abandoned and indices reset.
  - STALL: every word_valid is dropped and sets overflow. When fill_bank is freed by blk_ack -> WAIT_SYNC, so capture restarts sample-aligned.
- Realignment: word_first in FILL at channel != 0 sets sync_err. That word is written as channel 0 of the next sample index. Sample index wraps / completes the block as normal.
- word_first=0 at channel 0 is not an error.
- Handshake:
  - blk_valid=1 whenever any bank is full.
  - blk_bank = the older full bank.
  - blk_valid and blk_bank are stable until blk_ack.
  - blk_ack frees blk_bank in the same edge. blk_valid deasserts the next cycle unless the other bank is also full, in which case blk_bank switches.
  - blk_ack while blk_valid=0 is ignored.
- Same-cycle block completion and blk_ack of the other bank: the ack is processed first, so no stall.
- enable=0 does not release full banks; the handshake continues.
- overflow and sync_err clear only on reset.
- Asynchronous reset mid-block: immediate return to reset values, both banks free; partial data is discarded.

Optional Feature:
- ACQ_DROP_COUNT_EN
  - Defined: adds output drop_count [15:0], a saturating count of dropped words in STALL. Resets to 0 and saturates at 16'hFFFF.
  - Undefined: port absent; overflow flag only.

Decomposition:
- Package fecg_acq_pkg:
  - N_SAMPLES_DEF, N_CHANNELS_DEF, DATA_W_DEF;
  - SAMPLE_IDX_W and CH_IDX_W localparams;
  - acq_state_t enum {IDLE, WAIT_SYNC, FILL, STALL}.
- Sub-module: reuse the existing up_counter for the sample index. WIDTH=SAMPLE_IDX_W, MAX_VALUE=N_SAMPLES, enable = channel wrap; its max output flags block completion.
- The channel counter and bank bookkeeping stay inline.

Test Plan (N_SAMPLES=4, N_CHANNELS=2, so 8 words per block):
- Basic fill:
  - Stimulus: rst release, enable=1, 8 words 0x10..0x17, first on 0x10/0x12/0x14/0x16.
  - Response: wr_en pulses show bank0 (s,c) = (0,0)..(3,1) with matching data; blk_valid=1, blk_bank=0 one cycle after the last write.
- Ping-pong:
  - Stimulus: 16 back-to-back words, ack bank0 after word 12.
  - Response: words 9-16 go to bank1 with no gap; blk_bank 0 then 1; overflow=0.
- Overflow:
  - Stimulus: 16 words with no ack, then 3 more words, then ack bank0, then 1 non-first word, then a first word.
  - Response: STALL; overflow=1; with ACQ_DROP_COUNT_EN, drop_count=3 then 4. Capture resumes at the first word into bank0 at (0,0).
- Sync error:
  - Stimulus: word_first on the 2nd word of a sample.
  - Response: sync_err=1; that word written at (1,0).
- Reset and enable:
  - Stimulus: rst low after 5 words; then enable=0 mid-block.
  - Response: all outputs 0 and no blk_valid; enable=0 returns to IDLE with indices 0.
- Simultaneous events:
  - Stimulus: bank1 completes in the same cycle as blk_ack for bank0.
  - Response: no STALL; next word goes to bank0 at (0,0); blk_bank=1.
